// File: rtl/ddr_axi_pkg.sv
// Shared AXI read-path types for rid_fifo and axi_rresp_gen.
package ddr_axi_pkg;

  localparam int unsigned DEF_ID_W  = 4;
  localparam int unsigned DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_LEN_W-1:0] len;
  } rid_entry_t;

endpackage

// File: rtl/rdata_buf.sv
// Synchronous FIFO for PHY read beats; drops writes when full unless a pop frees a slot.
module rdata_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full,
  output logic         overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A same-cycle pop frees the slot being written when full.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/axi_rresp_gen.sv
// AXI R-channel generator: pairs rid_fifo entries with buffered in-order PHY beats.
// Optional RRESP_ERR_EN: carry phy_rerr through the buffer and report SLVERR per beat.
module axi_rresp_gen
  import ddr_axi_pkg::*;
#(
  parameter int unsigned ID_W      = DEF_ID_W,
  parameter int unsigned LEN_W     = DEF_LEN_W,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BUF_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [ID_W-1:0]   fifo_rid,
  input  logic [LEN_W-1:0]  fifo_rlen,
  output logic              fifo_pop,
  input  logic              phy_rvalid,
  input  logic [DATA_W-1:0] phy_rdata,
  input  logic              phy_rerr,
  output logic              rvalid,
  input  logic              rready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              buf_overflow,
  output logic              busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

`ifdef RRESP_ERR_EN
  localparam int unsigned PW = DATA_W + 1;
`else
  localparam int unsigned PW = DATA_W;
`endif

  logic [0:0]       state;
  logic [0:0]       state_n;
  logic [ID_W-1:0]  cur_id;
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W-1:0] beat_cnt;
  logic             pop_c;
  logic             load_c;
  logic             inc_c;
  logic             last_beat;
  logic             hs;
  logic [PW-1:0]    buf_wdata;
  logic [PW-1:0]    buf_head;
  logic             buf_empty;
  logic             buf_full;
  resp_t            resp_c;

`ifdef RRESP_ERR_EN
  assign buf_wdata = {phy_rerr, phy_rdata};
  assign resp_c    = buf_head[DATA_W] ? SLVERR : OKAY;
`else
  logic unused_rerr;
  logic unused_full;
  assign buf_wdata   = phy_rdata;
  assign resp_c      = OKAY;
  assign unused_rerr = phy_rerr;
  assign unused_full = buf_full;
`endif

  rdata_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (PW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (phy_rvalid),
    .wdata    (buf_wdata),
    .pop      (hs),
    .rdata    (buf_head),
    .empty    (buf_empty),
    .full     (buf_full),
    .overflow (buf_overflow)
  );

  // R-channel view: payload is zeroed whenever no beat is offered.
  assign rvalid    = (state == BURST) && !buf_empty;
  assign hs        = rvalid && rready;
  assign last_beat = (beat_cnt == cur_len);
  assign rid       = rvalid ? cur_id : '0;
  assign rdata     = rvalid ? buf_head[DATA_W-1:0] : '0;
  assign rresp     = rvalid ? resp_c : OKAY;
  assign rlast     = rvalid && last_beat;
  assign busy      = (state == BURST);
  assign fifo_pop  = pop_c && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state plus entry pop / reload; last-beat handshake can reload with no bubble.
  always_comb begin
    state_n = state;
    pop_c   = 1'b0;
    load_c  = 1'b0;
    inc_c   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          load_c  = 1'b1;
          state_n = BURST;
        end
      end
      BURST: begin
        if (hs) begin
          if (!last_beat) begin
            inc_c = 1'b1;
          end else if (!fifo_empty) begin
            pop_c  = 1'b1;
            load_c = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_id   <= '0;
      cur_len  <= '0;
      beat_cnt <= '0;
    end else if (load_c) begin
      cur_id   <= fifo_rid;
      cur_len  <= fifo_rlen;
      beat_cnt <= '0;
    end else if (inc_c) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_axi_rresp_gen.sv
// Self-checking bench for axi_rresp_gen: transaction-level model plus directed literal checks.
module tb_axi_rresp_gen;

  localparam int unsigned ID_W      = 4;
  localparam int unsigned LEN_W     = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BUF_DEPTH = 8;

  typedef struct packed {logic [ID_W-1:0] id; logic [LEN_W-1:0] len;} ent_t;
  typedef struct packed {logic e; logic [DATA_W-1:0] d;} beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_empty = 1'b1;
  logic [ID_W-1:0]   fifo_rid = '0;
  logic [LEN_W-1:0]  fifo_rlen = '0;
  logic              fifo_pop;
  logic              phy_rvalid = 1'b0;
  logic [DATA_W-1:0] phy_rdata = '0;
  logic              phy_rerr = 1'b0;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              buf_overflow;
  logic              busy;

  axi_rresp_gen #(
    .ID_W(ID_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rid(fifo_rid),
    .fifo_rlen(fifo_rlen), .fifo_pop(fifo_pop), .phy_rvalid(phy_rvalid),
    .phy_rdata(phy_rdata), .phy_rerr(phy_rerr), .rvalid(rvalid), .rready(rready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .buf_overflow(buf_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Environment rid_fifo and reference model state.
  ent_t  rf_q[$];
  beat_t data_q[$];
  logic  pending_pop = 1'b0;
  logic  m_active = 1'b0;
  logic  m_ovf = 1'b0;
  logic [ID_W-1:0] m_id = '0;
  int    m_len = 0;
  int    m_beat = 0;
  int    cyc = 0;

  // Observed handshakes, for directed literal checks.
  logic [ID_W-1:0]   lg_id[$];
  logic [DATA_W-1:0] lg_d[$];
  logic              lg_last[$];
  logic [1:0]        lg_resp[$];
  int                lg_cyc[$];
  int                lg_popcyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (rf_q.size() == 0);
    if (rf_q.size() != 0) begin
      fifo_rid  = rf_q[0].id;
      fifo_rlen = rf_q[0].len;
    end else begin
      fifo_rid  = '0;
      fifo_rlen = '0;
    end
  endtask

  // Model and compare, sampled mid-cycle.
  always @(negedge clk) begin : cmp
    logic  ev, hs, el, ep, acc;
    beat_t hd;
    cyc++;
    if (rst) begin
      data_q.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      if (rvalid && rready) begin
        lg_id.push_back(rid); lg_d.push_back(rdata);
        lg_last.push_back(rlast); lg_resp.push_back(rresp); lg_cyc.push_back(cyc);
      end
      if (fifo_pop) lg_popcyc.push_back(cyc);
      ev = m_active && (data_q.size() != 0);
      el = 1'b0;
      hd = '0;
      chk("rvalid", 64'(rvalid), 64'(ev));
      if (ev) begin
        hd = data_q[0];
        el = (m_beat == m_len);
        if (rvalid) begin
          chk("rid", 64'(rid), 64'(m_id));
          chk("rdata", 64'(rdata), 64'(hd.d));
          chk("rlast", 64'(rlast), 64'(el));
`ifdef RRESP_ERR_EN
          chk("rresp", 64'(rresp), hd.e ? 64'd2 : 64'd0);
`else
          chk("rresp", 64'(rresp), 64'd0);
`endif
        end
      end
      hs = ev && rready;
      ep = (rf_q.size() != 0) && (!m_active || (hs && el));
      chk("fifo_pop", 64'(fifo_pop), 64'(ep));
      chk("busy", 64'(busy), 64'(m_active));
      chk("buf_overflow", 64'(buf_overflow), 64'(m_ovf));
      acc = phy_rvalid && ((data_q.size() < BUF_DEPTH) || hs);
      if (hs) begin
        data_q.delete(0);
        if (el) m_active = 1'b0;
        else    m_beat++;
      end
      if (ep) begin
        m_active    = 1'b1;
        m_id        = rf_q[0].id;
        m_len       = int'(rf_q[0].len);
        m_beat      = 0;
        pending_pop = 1'b1;
      end
      if (phy_rvalid) begin
        if (acc) data_q.push_back({phy_rerr, phy_rdata});
        else     m_ovf = 1'b1;
      end
    end
  end

  task automatic step(input logic pv, input logic [DATA_W-1:0] d, input logic e, input logic rr);
    @(posedge clk); #1;
    if (pending_pop) begin
      rf_q.delete(0);
      pending_pop = 1'b0;
    end
    phy_rvalid = pv; phy_rdata = d; phy_rerr = e; rready = rr;
    refresh();
  endtask

  task automatic push_ent(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len);
    rf_q.push_back({id, len});
    refresh();
  endtask

  task automatic clear_log();
    lg_id.delete(); lg_d.delete(); lg_last.delete(); lg_resp.delete();
    lg_cyc.delete(); lg_popcyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rf_q.delete(); pending_pop = 1'b0;
    phy_rvalid = 1'b0; rready = 1'b0; phy_rerr = 1'b0;
    refresh();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int max_cyc);
    for (int i = 0; i < max_cyc && lg_d.size() < n; i++) step(1'b0, '0, 1'b0, 1'b1);
    chk("beat_count", 64'(lg_d.size()), 64'(n));
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_rvalid"}, 64'(rvalid), 64'd0);
    chk({tag, "_rid"}, 64'(rid), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata), 64'd0);
    chk({tag, "_rresp"}, 64'(rresp), 64'd0);
    chk({tag, "_rlast"}, 64'(rlast), 64'd0);
    chk({tag, "_fifo_pop"}, 64'(fifo_pop), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ovf"}, 64'(buf_overflow), 64'd0);
  endtask

  // One 4-beat burst {id, len=3}, full-rate rready, optional error on beat erri.
  task automatic run_single(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] base, input int erri);
    clear_log();
    step(1'b0, '0, 1'b0, 1'b1);
    push_ent(id, 8'd3);
    for (int i = 0; i < 4; i++) step(1'b1, base + DATA_W'(i), (i == erri), 1'b1);
    wait_beats(4, 20);
    for (int i = 0; i < 4 && i < lg_d.size(); i++) begin
      chk("single_rid", 64'(lg_id[i]), 64'(id));
      chk("single_rdata", 64'(lg_d[i]), 64'(base + DATA_W'(i)));
      chk("single_rlast", 64'(lg_last[i]), 64'(i == 3));
`ifdef RRESP_ERR_EN
      chk("single_rresp", 64'(lg_resp[i]), (i == erri) ? 64'd2 : 64'd0);
`else
      chk("single_rresp", 64'(lg_resp[i]), 64'd0);
`endif
    end
    chk("single_pops", 64'(lg_popcyc.size()), 64'd1);
  endtask

  initial begin
    logic rr_pat [4];
    rr_pat[0] = 1'b1; rr_pat[1] = 1'b0; rr_pat[2] = 1'b0; rr_pat[3] = 1'b1;
    refresh();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_zero("reset");

    // Single burst.
    run_single(4'd3, 32'hA0, -1);

    // Backpressure with rready 1,0,0,1 repeating.
    clear_log();
    step(1'b0, '0, 1'b0, 1'b0);
    push_ent(4'd3, 8'd3);
    for (int k = 0; k < 24; k++) step(k < 4, 32'hA0 + 32'(k), 1'b0, rr_pat[k % 4]);
    chk("bp_count", 64'(lg_d.size()), 64'd4);
    for (int i = 0; i < 4 && i < lg_d.size(); i++)
      chk("bp_rdata", 64'(lg_d[i]), 64'(32'hA0 + 32'(i)));

    // Back-to-back bursts with no bubble.
    clear_log();
    step(1'b0, '0, 1'b0, 1'b1);
    push_ent(4'd1, 8'd0);
    push_ent(4'd2, 8'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b1);
    wait_beats(3, 20);
    if (lg_d.size() >= 3 && lg_popcyc.size() >= 2) begin
      chk("b2b_rid0", 64'(lg_id[0]), 64'd1);
      chk("b2b_rid1", 64'(lg_id[1]), 64'd2);
      chk("b2b_rid2", 64'(lg_id[2]), 64'd2);
      chk("b2b_last0", 64'(lg_last[0]), 64'd1);
      chk("b2b_last1", 64'(lg_last[1]), 64'd0);
      chk("b2b_last2", 64'(lg_last[2]), 64'd1);
      chk("b2b_consec1", 64'(lg_cyc[1] - lg_cyc[0]), 64'd1);
      chk("b2b_consec2", 64'(lg_cyc[2] - lg_cyc[1]), 64'd1);
      chk("b2b_pop2_at_rlast", 64'(lg_popcyc[1]), 64'(lg_cyc[0]));
    end else begin
      chk("b2b_logged", 64'(lg_popcyc.size()), 64'd2);
    end

    // Overflow: 9 beats into an 8-deep buffer with rready low.
    do_reset();
    clear_log();
    step(1'b0, '0, 1'b0, 1'b0);
    push_ent(4'd5, 8'd7);
    for (int i = 0; i < 9; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("ovf_set", 64'(buf_overflow), 64'd1);
    wait_beats(8, 20);
    for (int i = 0; i < 8 && i < lg_d.size(); i++) begin
      chk("ovf_rdata", 64'(lg_d[i]), 64'(32'h100 + 32'(i)));
      chk("ovf_rlast", 64'(lg_last[i]), 64'(i == 7));
    end
    chk("ovf_sticky", 64'(buf_overflow), 64'd1);

    // Reset after 2 of 4 beats, then a fresh burst.
    do_reset();
    clear_log();
    step(1'b0, '0, 1'b0, 1'b1);
    push_ent(4'd6, 8'd3);
    for (int i = 0; i < 12; i++) begin
      step(i < 4, 32'hC0 + 32'(i), 1'b0, 1'b1);
      if (lg_d.size() >= 2) break;
    end
    chk("rst_mid_seen2", 64'(lg_d.size()), 64'd2);
    rst = 1'b1; phy_rvalid = 1'b0; rf_q.delete(); pending_pop = 1'b0; refresh();
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_zero("rst_mid");
    run_single(4'd3, 32'hA0, -1);

    // Per-beat error flag on beat 2 of 4.
    run_single(4'd4, 32'hD0, 1);

    // Longest burst: 256 beats, counter must end before wrap.
    do_reset();
    clear_log();
    step(1'b0, '0, 1'b0, 1'b1);
    push_ent(4'd7, 8'd255);
    for (int i = 0; i < 256; i++) step(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b1);
    wait_beats(256, 20);
    if (lg_d.size() == 256) begin
      chk("long_last255", 64'(lg_last[255]), 64'd1);
      chk("long_last254", 64'(lg_last[254]), 64'd0);
      chk("long_last0", 64'(lg_last[0]), 64'd0);
    end
    chk("long_busy_after", 64'(busy), 64'd0);

    // Randomized traffic checked by the model.
    for (int blk = 0; blk < 5; blk++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        step($urandom_range(0, 99) < 40, $urandom, $urandom_range(0, 3) == 0,
             $urandom_range(0, 99) < 70);
        if (rf_q.size() < 4 && $urandom_range(0, 7) == 0)
          push_ent(ID_W'($urandom), ($urandom_range(0, 15) == 0) ?
                   LEN_W'($urandom_range(4, 20)) : LEN_W'($urandom_range(0, 3)));
      end
    end

    step(1'b0, '0, 1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
